// File: rtl/ps2_pkg.sv
// Shared scan-code, FSM-state, ASCII and action constants for the PS/2 keyboard path.
// SHIFT_CASE_EN adds the lowercase and shifted-digit ASCII constants.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GOT_F0   = 2'd1;
    localparam logic [1:0] ST_GOT_E0   = 2'd2;
    localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

    localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_MINUS    = 8'h2D;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_RBRACKET = 8'h5D;
`ifdef SHIFT_CASE_EN
    localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
    localparam logic [7:0] ASCII_LPAREN   = 8'h28;
    localparam logic [7:0] ASCII_RPAREN   = 8'h29;
`endif

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_CHAR  = 2'd1,
        ACT_ENTER = 2'd2,
        ACT_BKSP  = 2'd3
    } action_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational translation of a PS/2 set-2 make code into an action and ASCII byte.
// SHIFT_CASE_EN selects lowercase letters and shifted '9'/'0' when shift is not/is held.
module scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       shift,
    output logic [1:0] action,
    output logic [7:0] ascii
);

    logic       is_letter;
    logic [4:0] letter_idx;
    logic       is_digit;
    logic [3:0] digit;
    logic [7:0] letter_base;

`ifdef SHIFT_CASE_EN
    assign letter_base = shift ? ASCII_UPPER_A : ASCII_LOWER_A;
`else
    logic unused_shift;
    assign unused_shift = shift;
    assign letter_base  = ASCII_UPPER_A;
`endif

    always_comb begin
        is_letter  = 1'b1;
        letter_idx = 5'd0;
        case (scan_code)
            8'h1C: letter_idx = 5'd0;
            8'h32: letter_idx = 5'd1;
            8'h21: letter_idx = 5'd2;
            8'h23: letter_idx = 5'd3;
            8'h24: letter_idx = 5'd4;
            8'h2B: letter_idx = 5'd5;
            8'h34: letter_idx = 5'd6;
            8'h33: letter_idx = 5'd7;
            8'h43: letter_idx = 5'd8;
            8'h3B: letter_idx = 5'd9;
            8'h42: letter_idx = 5'd10;
            8'h4B: letter_idx = 5'd11;
            8'h3A: letter_idx = 5'd12;
            8'h31: letter_idx = 5'd13;
            8'h44: letter_idx = 5'd14;
            8'h4D: letter_idx = 5'd15;
            8'h15: letter_idx = 5'd16;
            8'h2D: letter_idx = 5'd17;
            8'h1B: letter_idx = 5'd18;
            8'h2C: letter_idx = 5'd19;
            8'h3C: letter_idx = 5'd20;
            8'h2A: letter_idx = 5'd21;
            8'h1D: letter_idx = 5'd22;
            8'h22: letter_idx = 5'd23;
            8'h35: letter_idx = 5'd24;
            8'h1A: letter_idx = 5'd25;
            default: is_letter = 1'b0;
        endcase

        is_digit = 1'b1;
        digit    = 4'd0;
        case (scan_code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase

        action = ACT_NONE;
        ascii  = 8'h00;
        if (is_letter) begin
            action = ACT_CHAR;
            ascii  = letter_base + {3'b000, letter_idx};
        end else if (is_digit) begin
            action = ACT_CHAR;
            ascii  = ASCII_ZERO + {4'b0000, digit};
`ifdef SHIFT_CASE_EN
            if (shift && digit == 4'd9) ascii = ASCII_LPAREN;
            if (shift && digit == 4'd0) ascii = ASCII_RPAREN;
`endif
        end else begin
            case (scan_code)
                8'h29: begin action = ACT_CHAR; ascii = ASCII_SPACE;    end
                8'h4E: begin action = ACT_CHAR; ascii = ASCII_MINUS;    end
                8'h54: begin action = ACT_CHAR; ascii = ASCII_LBRACKET; end
                8'h5B: begin action = ACT_CHAR; ascii = ASCII_RBRACKET; end
                SC_ENTER: action = ACT_ENTER;
                SC_BKSP:  action = ACT_BKSP;
                // Shift keys never produce a character; their held state lives in the top.
                SC_SHIFT_L, SC_SHIFT_R: action = ACT_NONE;
                default: action = ACT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_command_sequencer.sv
// Scan-code FSM, four-character word packer and show-ahead output FIFO for the keyboard path.
// SHIFT_CASE_EN adds left/right shift tracking that drives letter case and '('/')'.
module ps2_command_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ps2_info,
    input  logic        ps2_enable,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        overflow
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pack_q, pack_d;
    logic [1:0]  idx_q, idx_d;
    logic        push_v_q, push_v_d;
    logic [31:0] push_word_q, push_word_d;
    logic        push_last_q, push_last_d;

    logic [31:0]           mem_q [FIFO_DEPTH];
    logic [31:0]           mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q, last_d;
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;

    logic       shift_held;
    logic [1:0] sc_action;
    logic [7:0] sc_ascii;

`ifdef SHIFT_CASE_EN
    logic shift_l_q, shift_l_d;
    logic shift_r_q, shift_r_d;
    assign shift_held = shift_l_q | shift_r_q;
`else
    assign shift_held = 1'b0;
`endif

    scancode_to_ascii u_xlate (
        .scan_code (ps2_info),
        .shift     (shift_held),
        .action    (sc_action),
        .ascii     (sc_ascii)
    );

    // Scan FSM and packer; a completed word is staged one cycle in push_*_q before the FIFO.
    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        idx_d       = idx_q;
        push_v_d    = 1'b0;
        push_word_d = push_word_q;
        push_last_d = push_last_q;
`ifdef SHIFT_CASE_EN
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
`endif
        if (ps2_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_info == SC_BREAK) begin
                        state_d = ST_GOT_F0;
                    end else if (ps2_info == SC_EXT) begin
                        state_d = ST_GOT_E0;
                    end else begin
`ifdef SHIFT_CASE_EN
                        if (ps2_info == SC_SHIFT_L) shift_l_d = 1'b1;
                        if (ps2_info == SC_SHIFT_R) shift_r_d = 1'b1;
`endif
                        if (sc_action == ACT_CHAR) begin
                            if (idx_q == 2'd3) begin
                                push_v_d    = 1'b1;
                                push_word_d = {pack_q[31:8], sc_ascii};
                                push_last_d = 1'b0;
                                pack_d      = '0;
                                idx_d       = 2'd0;
                            end else begin
                                case (idx_q)
                                    2'd0:    pack_d[31:24] = sc_ascii;
                                    2'd1:    pack_d[23:16] = sc_ascii;
                                    default: pack_d[15:8]  = sc_ascii;
                                endcase
                                idx_d = idx_q + 2'd1;
                            end
                        end else if (sc_action == ACT_ENTER) begin
                            push_v_d    = 1'b1;
                            push_word_d = pack_q;
                            push_last_d = 1'b1;
                            pack_d      = '0;
                            idx_d       = 2'd0;
                        end else if (sc_action == ACT_BKSP) begin
                            case (idx_q)
                                2'd1:    pack_d[31:24] = 8'h00;
                                2'd2:    pack_d[23:16] = 8'h00;
                                2'd3:    pack_d[15:8]  = 8'h00;
                                default: ;
                            endcase
                            if (idx_q != 2'd0) idx_d = idx_q - 2'd1;
                        end
                    end
                end
                ST_GOT_F0: begin
`ifdef SHIFT_CASE_EN
                    if (ps2_info == SC_SHIFT_L) shift_l_d = 1'b0;
                    if (ps2_info == SC_SHIFT_R) shift_r_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
                ST_GOT_E0: begin
                    state_d = (ps2_info == SC_BREAK) ? ST_GOT_E0F0 : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              fifo_empty, fifo_full, pop, wr_en;

    assign wr_addr    = wr_ptr_q[ADDR_W-1:0];
    assign rd_addr    = rd_ptr_q[ADDR_W-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pop        = !fifo_empty && out_ready;
    // When full, a simultaneous pop frees the slot the push overwrites.
    assign wr_en      = push_v_q && (!fifo_full || pop);

    always_comb begin
        mem_d      = mem_q;
        last_d     = last_q;
        if (wr_en) begin
            mem_d[wr_addr]  = push_word_q;
            last_d[wr_addr] = push_last_q;
        end
        wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(pop);
        overflow_d = overflow_q | (push_v_q && fifo_full && !pop);
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'h0 : mem_q[rd_addr];
    assign out_last  = !fifo_empty && last_q[rd_addr];
    assign overflow  = overflow_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pack_q      <= '0;
            idx_q       <= 2'd0;
            push_v_q    <= 1'b0;
            push_word_q <= '0;
            push_last_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            last_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
`ifdef SHIFT_CASE_EN
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            idx_q       <= idx_d;
            push_v_q    <= push_v_d;
            push_word_q <= push_word_d;
            push_last_q <= push_last_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
`ifdef SHIFT_CASE_EN
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Bench for ps2_command_sequencer: directed vector table, multi-cycle corner sequences and
// random scan-code streams checked against a line-buffer model. Honours SHIFT_CASE_EN.
module tb_ps2_command_sequencer;

    localparam int FIFO_DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ps2_info;
    logic        ps2_enable;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;

    ps2_command_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_info   (ps2_info),
        .ps2_enable (ps2_enable),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit auto_ready = 1'b0;
    bit model_mute = 1'b0;

    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: scan-code rules over a character line ----------------
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};
    logic [7:0] special_codes [4] = '{8'h29, 8'h4E, 8'h54, 8'h5B};

    logic [7:0] line_q[$];
    bit m_brk = 0, m_ext = 0, m_sl = 0, m_sr = 0;

    task automatic model_emit(input logic last);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < line_q.size(); i++) w[31-8*i -: 8] = line_q[i];
        line_q.delete();
        if (!model_mute) exp_q.push_back({last, w});
    endtask

    // kind: 0 ignored, 1 character, 2 enter, 3 backspace
    task automatic model_xlate(input logic [7:0] b, input bit shift, output int kind, output logic [7:0] ch);
        kind = 0;
        ch   = 8'h00;
        for (int i = 0; i < 26; i++) if (b == letter_codes[i]) begin
            kind = 1;
`ifdef SHIFT_CASE_EN
            ch = (shift ? 8'h41 : 8'h61) + 8'(i);
`else
            ch = 8'h41 + 8'(i);
`endif
        end
        for (int i = 0; i < 10; i++) if (b == digit_codes[i]) begin
            kind = 1;
            ch   = 8'h30 + 8'(i);
`ifdef SHIFT_CASE_EN
            if (shift && i == 9) ch = 8'h28;
            if (shift && i == 0) ch = 8'h29;
`endif
        end
        case (b)
            8'h29: begin kind = 1; ch = 8'h20; end
            8'h4E: begin kind = 1; ch = 8'h2D; end
            8'h54: begin kind = 1; ch = 8'h5B; end
            8'h5B: begin kind = 1; ch = 8'h5D; end
            8'h5A: kind = 2;
            8'h66: kind = 3;
            default: ;
        endcase
        if (shift && 1'b0) kind = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int kind;
        logic [7:0] ch;
        if (m_brk) begin
`ifdef SHIFT_CASE_EN
            if (!m_ext && b == 8'h12) m_sl = 0;
            if (!m_ext && b == 8'h59) m_sr = 0;
`endif
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_ext) begin
            m_ext = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
`ifdef SHIFT_CASE_EN
            if (b == 8'h12) m_sl = 1;
            if (b == 8'h59) m_sr = 1;
`endif
            model_xlate(b, m_sl | m_sr, kind, ch);
            if (kind == 1) begin
                line_q.push_back(ch);
                if (line_q.size() == 4) model_emit(1'b0);
            end else if (kind == 2) begin
                model_emit(1'b1);
            end else if (kind == 3 && line_q.size() > 0) begin
                void'(line_q.pop_back());
            end
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        exp_q.delete();
        m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0;
    endtask

    function automatic logic [31:0] lc(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef SHIFT_CASE_EN
        for (int i = 0; i < 4; i++)
            if (r[8*i +: 8] >= 8'h41 && r[8*i +: 8] <= 8'h5A) r[8*i +: 8] = r[8*i +: 8] + 8'h20;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        ps2_info   = b;
        ps2_enable = 1'b1;
        model_byte(b);
        @(negedge clock);
        ps2_enable = 1'b0;
        ps2_info   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- consumer and scoreboard ----------------
    initial forever begin
        @(negedge clock);
        if (auto_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        logic [32:0] e;
        @(negedge clock);
        #1;
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word got %h last %0d expected no word", out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                check("word_data", out_data, e[31:0]);
                check("word_last", {31'b0, out_last}, {31'b0, e[32]});
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [63:0] seq;
        logic [3:0]  n;
        logic [31:0] word;
        logic        last;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    initial begin
        int pops0;
        logic [7:0] b;
        int r, g;

        tbl[0]  = '{64'h1C322123_00000000, 4'd4, lc(32'h41424344), 1'b0};
        tbl[1]  = '{64'h4DF04D5A_00000000, 4'd4, lc(32'h50000000), 1'b1};
        tbl[2]  = '{64'h2C2C665A_00000000, 4'd4, lc(32'h54000000), 1'b1};
        tbl[3]  = '{64'h5A000000_00000000, 4'd1, 32'h00000000,     1'b1};
        tbl[4]  = '{64'hE075E0F0_751C5A00, 4'd7, lc(32'h41000000), 1'b1};
        tbl[5]  = '{64'h45161E26_00000000, 4'd4, 32'h30313233,     1'b0};
        tbl[6]  = '{64'h252E363D_00000000, 4'd4, 32'h34353637,     1'b0};
        tbl[7]  = '{64'h3E46294E_00000000, 4'd4, 32'h3839202D,     1'b0};
        tbl[8]  = '{64'h545B6666_665A0000, 4'd6, 32'h00000000,     1'b1};
        tbl[9]  = '{64'h0576661C_5A000000, 4'd5, lc(32'h41000000), 1'b1};
`ifdef SHIFT_CASE_EN
        tbl[10] = '{64'h1C121CF0_121C5A00, 4'd7, 32'h61416100,     1'b1};
`else
        tbl[10] = '{64'h1C121CF0_121C5A00, 4'd7, 32'h41414100,     1'b1};
`endif
        tbl[11] = '{64'h242B3433_00000000, 4'd4, lc(32'h45464748), 1'b0};
        tbl[12] = '{64'h1C32215A_00000000, 4'd4, lc(32'h41424300), 1'b1};

        // reset block
        reset      = 1'b0;
        ps2_info   = 8'h00;
        ps2_enable = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_out_data", out_data, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_last", {31'b0, out_last}, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // first-word latency: out_valid rises two cycles after the completing strobe
        out_ready = 1'b1;
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        check("latency_n1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clock);
        check("latency_n2_valid", {31'b0, out_valid}, 32'd1);
        wait_drain();

        // table-driven vectors
        model_mute = 1'b1;
        auto_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            exp_q.push_back({tbl[v].last, tbl[v].word});
            for (int k = 0; k < int'(tbl[v].n); k++) send_byte(tbl[v].seq[63-8*k -: 8]);
            wait_drain();
        end
        model_mute = 1'b0;

        // fill the FIFO, then push exactly in a popping cycle while full, then overflow
        auto_ready = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            send_byte(letter_codes[i]);
            send_byte(8'h5A);
        end
        repeat (3) @(negedge clock);
        check("full_valid", {31'b0, out_valid}, 32'd1);
        check("full_no_overflow", {31'b0, overflow}, 32'd0);
        send_byte(letter_codes[8]);
        send_byte(8'h5A);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("push_pop_full_overflow", {31'b0, overflow}, 32'd0);
        model_mute = 1'b1;
        send_byte(letter_codes[9]);
        send_byte(8'h5A);
        model_mute = 1'b0;
        repeat (3) @(negedge clock);
        check("overflow_set", {31'b0, overflow}, 32'd1);
        check("overflow_valid", {31'b0, out_valid}, 32'd1);
        pops0 = pops;
        auto_ready = 1'b1;
        wait_drain();
        repeat (3) @(negedge clock);
        check("drain_pop_count", 32'(pops - pops0), 32'd8);
        check("drained_valid", {31'b0, out_valid}, 32'd0);
        check("overflow_sticky", {31'b0, overflow}, 32'd1);

        // reset mid-line with a buffered word
        auto_ready = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h5A);
        send_byte(8'h32);
        repeat (3) @(negedge clock);
        check("preflush_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_out_data", out_data, 32'h0);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_out_last", {31'b0, out_last}, 32'd0);
        check("midreset_overflow", {31'b0, overflow}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        send_byte(8'h5A);
        wait_drain();

        // random scan-code stream against the model
        auto_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            g = 0;
            while (exp_q.size() > FIFO_DEPTH - 2 && g < 500) begin
                @(negedge clock);
                g++;
            end
            r = $urandom_range(0, 99);
            if (r < 45)      b = letter_codes[$urandom_range(0, 25)];
            else if (r < 55) b = digit_codes[$urandom_range(0, 9)];
            else if (r < 62) b = special_codes[$urandom_range(0, 3)];
            else if (r < 70) b = 8'h5A;
            else if (r < 76) b = 8'h66;
            else if (r < 84) b = 8'hF0;
            else if (r < 89) b = 8'hE0;
            else if (r < 93) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        send_byte(8'h5A);
        wait_drain();
        check("random_overflow", {31'b0, overflow}, 32'd0);
        check("random_idle_valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Sequences the keyboard path: consumes PS/2 scan-code bytes, strips break/extended sequences, translates make codes to ASCII and packs characters four-per-word.
- Buffers the packed words in a small FIFO and hands them to the command interpreter over a valid/ready interface.
- Enter marks the final word of each command line.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit words buffered; must be a power of two.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_info  input  8  scan-code byte from the PS/2 receiver.
- ps2_enable  input  1  one-cycle strobe; ps2_info is valid in that cycle.
- out_data  output  32  packed characters; first character in [31:24], last in [7:0], unused bytes are 0x00.
- out_valid  output  1  FIFO head holds a word.
- out_ready  input  1  consumer accepts; a word pops when out_valid and out_ready are both high.
- out_last  output  1  head word ends a command line (Enter).
- overflow  output  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE, packer cleared, packer index 0, FIFO emptied.
  - out_data=0, out_valid=0, out_last=0, overflow=0.
- Bytes are processed only in cycles where ps2_enable=1; otherwise all state holds.
- Scan FSM states and transitions:
  - IDLE: 0xF0 -> GOT_F0. 0xE0 -> GOT_E0. Any other byte is a make code: translate, stay IDLE.
  - GOT_F0: the byte is discarded -> IDLE.
  - GOT_E0: 0xF0 -> GOT_E0F0. Any other byte is discarded -> IDLE. Extended keys are ignored.
  - GOT_E0F0: any byte -> IDLE.
- Translation (make codes):
  - Letters map to ASCII 0x41-0x5A.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9'.
  - 0x29 -> 0x20 (space); 0x4E -> '-'; 0x54 -> '['; 0x5B -> ']'.
  - 0x5A -> ENTER action; 0x66 -> BACKSPACE action.
  - All other codes are ignored with no state change.
- Packer:
  - Each character is written at byte (3-index), then the index increments.
  - At index 3, the character completes the word: it is pushed with last=0, and the packer and index clear.
- ENTER: pushes the current packer word zero-filled with last=1, even when empty (0x00000000), then clears the packer.
- BACKSPACE:
  - index>0: clear byte at (3-(index-1)) and decrement the index.
  - index=0: ignored. Words already pushed are never retracted.
- Latency: the make-code byte strobed in cycle n is applied to the packer at the edge ending cycle n. Any resulting push is written at the next edge. With the FIFO empty, out_valid rises in cycle n+2.
- FIFO:
  - Show-ahead: out_data and out_last reflect the head combinationally from registers.
  - Push with pop in the same cycle is always accepted, including when full.
  - Push when full without a pop: the word is dropped and overflow is set to 1. It clears only on reset.
  - Pointers are ADDR_W+1 bits and wrap naturally. Full and empty are derived from the MSB compare.
- Reset mid-line: the partial packer content is lost and no word is emitted.

Optional Feature:
- SHIFT_CASE_EN defined:
  - Tracks left/right shift (make 0x12/0x59 sets held; break F0 12 / F0 59 clears). The GOT_F0 state inspects the byte for this.
  - Letters are lowercase 0x61-0x7A unless a shift is held.
  - Shift-held '9'/'0' produce '('/')'.
  - Shift state is cleared on reset.
- Undefined: shift codes are ignored and letters are always uppercase.

Decomposition:
- Package ps2_pkg:
  - Scan-code constants (BREAK 0xF0, EXT 0xE0, ENTER 0x5A, BKSP 0x66, SHIFT_L 0x12, SHIFT_R 0x59).
  - FSM state encoding (2 bits).
  - ASCII constants.
  - Action encoding (NONE/CHAR/ENTER/BKSP).
- Sub-module scancode_to_ascii: combinational. Inputs are the scan code and shift; outputs are the action and the ASCII byte.
- The FIFO is kept inline.

Test Plan:
- Strobe 0x1C,0x32,0x21,0x23 (A,B,C,D) with out_ready=1 -> out_data=0x41424344, out_last=0, out_valid first high 2 cycles after the 0x23 strobe.
- Strobe 0x4D, 0xF0, 0x4D, 0x5A (P, P-release, Enter) -> single word 0x50000000 with out_last=1; the break pair adds nothing.
- Strobe 0x2C, 0x2C, 0x66, 0x5A (T,T,BKSP,Enter) -> 0x54000000 with last=1. Enter alone -> 0x00000000 with last=1.
- Strobe 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x1C, 0x5A -> only 0x41000000 with last=1 is emitted.
- out_ready=0, push 9 Enter words -> 8 buffered, overflow=1. Then drain -> exactly 8 pops, out_valid falls, overflow stays 1 until reset=0.
- SHIFT_CASE_EN: 0x1C, then 0x12, 0x1C, 0xF0, 0x12, 0x1C, 0x5A -> 0x61416100 last=1. Assert reset low mid-line -> all outputs 0 immediately.
